// File: rtl/rgb_led_seq.sv
// rgb_led_seq: colour-step sequencer with per-channel PWM for the two board RGB LEDs.
// A small table holds one {R,G,B} duty triple per step per LED. The sequencer walks
// the table at 2^div_i PWM periods per step, in loop or one-shot mode, and every
// channel is a registered comparison of the shared 8-bit PWM counter with a shadow duty.
module rgb_led_seq #(
    parameter int PRESCALE  = 390,
    parameter int NUM_STEPS = 4
) (
    input  logic                         clk100,
    input  logic                         rstn,
    input  logic                         en_i,
    input  logic                         mode_i,
    input  logic [4:0]                   div_i,
    input  logic                         wren_i,
    input  logic [$clog2(NUM_STEPS)-1:0] wstep_i,
    input  logic                         wled_i,
    input  logic [23:0]                  wdata_i,
    output logic [2:0]                   led_0_o,
    output logic [2:0]                   led_1_o,
    output logic [$clog2(NUM_STEPS)-1:0] step_o,
    output logic                         done_o
);

    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam int PRE_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of PWM periods in one step; anything above 2^5 clamps to 32 periods.
    function automatic logic [5:0] step_len(input logic [4:0] div);
        logic [5:0] len;
        len = 6'd32;
        if (div <= 5'd5) begin
            len = 6'd1 << div[2:0];
        end
        return len;
    endfunction

    // One LED's three channels: lit while the PWM count is below the channel duty.
    function automatic logic [2:0] pwm_bits(input logic [7:0] cnt, input logic [23:0] duty);
        return {cnt < duty[23:16], cnt < duty[15:8], cnt < duty[7:0]};
    endfunction

    // Reset synchroniser: rstn asserts immediately, releases two clocks after it rises.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    // Shift ones into the release chain once rstn is high.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Colour table storage, one array per LED.
    logic [23:0] tab_0_q [NUM_STEPS];
    logic [23:0] tab_0_d [NUM_STEPS];
    logic [23:0] tab_1_q [NUM_STEPS];
    logic [23:0] tab_1_d [NUM_STEPS];

    // Sequencer state.
    state_t              state_q,    state_d;
    logic                mode_q,     mode_d;
    logic [5:0]          len_q,      len_d;
    logic [PRE_W-1:0]    presc_q,    presc_d;
    logic [7:0]          pwm_q,      pwm_d;
    logic [5:0]          per_q,      per_d;
    logic [STEP_W-1:0]   step_q,     step_d;
    logic [23:0]         shadow_0_q, shadow_0_d;
    logic [23:0]         shadow_1_q, shadow_1_d;
    logic [2:0]          led_0_q,    led_0_d;
    logic [2:0]          led_1_q,    led_1_d;
    logic                done_q,     done_d;

    logic                tick;
    logic                period_end;
    logic [5:0]          per_inc;
    logic [STEP_W-1:0]   step_next;

    // Table writes land in the array at the next edge, so a load on that same edge sees the old entry.
    always_comb begin
        tab_0_d = tab_0_q;
        tab_1_d = tab_1_q;
        if (wren_i) begin
            if (wled_i) begin
                tab_1_d[wstep_i] = wdata_i;
            end else begin
                tab_0_d[wstep_i] = wdata_i;
            end
        end
    end

    // Table registers; cleared by reset like everything else.
    always_ff @(posedge clk100 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                tab_0_q[i] <= '0;
                tab_1_q[i] <= '0;
            end
        end else begin
            tab_0_q <= tab_0_d;
            tab_1_q <= tab_1_d;
        end
    end

    // Next-state logic for the sequencer, counters, shadow duties and PWM outputs.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        presc_d    = presc_q;
        pwm_d      = pwm_q;
        per_d      = per_q;
        step_d     = step_q;
        shadow_0_d = shadow_0_q;
        shadow_1_d = shadow_1_q;
        led_0_d    = led_0_q;
        led_1_d    = led_1_q;
        done_d     = done_q;

        tick       = (presc_q == PRE_LAST);
        period_end = tick && (pwm_q == 8'hFF);
        per_inc    = per_q + 6'd1;
        step_next  = step_q + STEP_W'(1);

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                pwm_d   = '0;
                per_d   = '0;
                step_d  = '0;
                led_0_d = '0;
                led_1_d = '0;
                done_d  = 1'b0;
                if (en_i) begin
                    state_d    = ST_RUN;
                    mode_d     = mode_i;
                    len_d      = step_len(div_i);
                    shadow_0_d = tab_0_q[0];
                    shadow_1_d = tab_1_q[0];
                end
            end

            ST_RUN, ST_DONE: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    pwm_d   = '0;
                    per_d   = '0;
                    step_d  = '0;
                    led_0_d = '0;
                    led_1_d = '0;
                    done_d  = 1'b0;
                end else begin
                    presc_d = tick ? '0 : presc_q + PRE_W'(1);
                    if (tick) begin
                        pwm_d = pwm_q + 8'd1;
                    end
                    led_0_d = pwm_bits(pwm_q, shadow_0_q);
                    led_1_d = pwm_bits(pwm_q, shadow_1_q);

                    // Once in DONE the shadows are frozen and the step no longer moves.
                    if (period_end && (state_q == ST_RUN)) begin
                        if (per_inc == len_q) begin
                            if (mode_q && (step_q == STEP_LAST)) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                step_d     = step_next;
                                per_d      = '0;
                                len_d      = step_len(div_i);
                                shadow_0_d = tab_0_q[step_next];
                                shadow_1_d = tab_1_q[step_next];
                            end
                        end else begin
                            per_d      = per_inc;
                            shadow_0_d = tab_0_q[step_q];
                            shadow_1_d = tab_1_q[step_q];
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers, including the registered LED and status outputs.
    always_ff @(posedge clk100 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            len_q      <= 6'd1;
            presc_q    <= '0;
            pwm_q      <= '0;
            per_q      <= '0;
            step_q     <= '0;
            shadow_0_q <= '0;
            shadow_1_q <= '0;
            led_0_q    <= '0;
            led_1_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            presc_q    <= presc_d;
            pwm_q      <= pwm_d;
            per_q      <= per_d;
            step_q     <= step_d;
            shadow_0_q <= shadow_0_d;
            shadow_1_q <= shadow_1_d;
            led_0_q    <= led_0_d;
            led_1_q    <= led_1_d;
            done_q     <= done_d;
        end
    end

    assign led_0_o = led_0_q;
    assign led_1_o = led_1_q;
    assign step_o  = step_q;
    assign done_o  = done_q;

endmodule
